// File: rtl/roic_scan_pkg.sv
// Shared types and helpers for the ROIC pixel scanner: FSM states, scan modes
// and readout-window sanitising.
package roic_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INTG = 3'd1,
    ST_INTG      = 3'd2,
    ST_SCAN      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] MODE_FULL  = 2'd0;
  localparam logic [1:0] MODE_DEC2  = 2'd1;
  localparam logic [1:0] MODE_STARE = 2'd2;

  // Returns the sanitised start (want_end=0) or end (want_end=1) of one axis:
  // the end clamps to n-1, and an inverted window falls back to 0..n-1.
  function automatic int unsigned clamp_window(input int unsigned start,
                                               input int unsigned stop,
                                               input int unsigned n,
                                               input bit          want_end);
    int unsigned hi;
    hi = (stop >= n) ? n - 1 : stop;
    if (start > hi) return want_end ? n - 1 : 0;
    return want_end ? hi : start;
  endfunction

endpackage

// File: rtl/scan_axis_counter.sv
// One scan axis: start/end/step index counter with wrap flag and a registered
// one-hot select that is only driven while the axis is visible.
module scan_axis_counter
  import roic_scan_pkg::*;
#(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic         i_step2,
  input  logic [W-1:0] i_start,
  input  logic [W-1:0] i_stop,
  input  logic         i_vis,
  output logic [W-1:0] o_idx,
  output logic [N-1:0] o_onehot,
  output logic         o_last
);

  localparam logic [N-1:0] ONE = 1;

  logic [W-1:0] r_idx;
  logic [W-1:0] w_idx_nxt;
  logic [W:0]   w_stepped;
  logic [N-1:0] r_oh;

  always_comb begin
    w_stepped = {1'b0, r_idx} + (i_step2 ? (W+1)'(2) : (W+1)'(1));
    w_idx_nxt = r_idx;
    if (i_load)    w_idx_nxt = i_start;
    else if (i_en) w_idx_nxt = w_stepped[W-1:0];
  end

  // Last position reached when one more step would pass the window end.
  assign o_last = w_stepped > {1'b0, i_stop};

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_idx <= '0;
      r_oh  <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      r_oh  <= i_vis ? (ONE << w_idx_nxt) : '0;
    end
  end

  assign o_idx    = r_idx;
  assign o_onehot = r_oh;

endmodule

// File: rtl/roic_pixel_scanner.sv
// ROWS x COLS ROIC row/column select sequencer: frame handshake FSM, settle and
// dwell timing, windowed/decimated/stare scan, ADC stall and sample strobe.
module roic_pixel_scanner
  import roic_scan_pkg::*;
#(
  parameter int ROWS       = 16,
  parameter int COLS       = 16,
  parameter int DWELL      = 3,
  parameter int ROW_SETTLE = 1,
  parameter int RW         = $clog2(ROWS),
  parameter int CW         = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            master_rst,
  input  logic            fsync,
  input  logic            intg,
  input  logic [1:0]      mode,
  input  logic [RW-1:0]   win_r0,
  input  logic [RW-1:0]   win_r1,
  input  logic [CW-1:0]   win_c0,
  input  logic [CW-1:0]   win_c1,
  input  logic            adc_busy,
  output logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic            pix_valid,
  output logic [RW-1:0]   row_idx,
  output logic [CW-1:0]   col_idx,
  output logic            frame_done,
  output logic [2:0]      state
);

  localparam int CMAX = (DWELL > ROW_SETTLE) ? DWELL : ROW_SETTLE;
  localparam int CNTW = $clog2(CMAX + 1);
  localparam logic [CNTW-1:0] DWELL_LAST  = CNTW'(DWELL - 1);
  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'((ROW_SETTLE > 0) ? ROW_SETTLE - 1 : 0);
  localparam logic PIX_ON_ENTRY = (DWELL == 1);

  state_t          r_state, w_state_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic            r_settle, w_settle_nxt;
  logic            r_pix, w_pix_nxt;
  logic            r_done, w_done_nxt;
  logic [RW-1:0]   r_r0, r_r1;
  logic [CW-1:0]   r_c0, r_c1;
  logic            r_dec2, r_stare;
  logic            w_row_load, w_row_en, w_row_vis, w_row_last;
  logic            w_col_load, w_col_en, w_col_vis, w_col_last;

  assign w_cnt_inc = r_cnt + CNTW'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_settle_nxt = r_settle;
    w_pix_nxt    = 1'b0;
    w_done_nxt   = 1'b0;
    w_row_load   = 1'b0;
    w_row_en     = 1'b0;
    w_row_vis    = 1'b0;
    w_col_load   = 1'b0;
    w_col_en     = 1'b0;
    w_col_vis    = 1'b0;

    case (r_state)
      ST_IDLE:      if (fsync) w_state_nxt = ST_WAIT_INTG;
      ST_WAIT_INTG: if (intg)  w_state_nxt = ST_INTG;
      ST_INTG: begin
        if (!intg) begin
          w_state_nxt = ST_SCAN;
          w_row_load  = 1'b1;
          w_col_load  = 1'b1;
          w_row_vis   = 1'b1;
          w_cnt_nxt   = '0;
          if (ROW_SETTLE > 0) begin
            w_settle_nxt = 1'b1;
          end else begin
            w_settle_nxt = 1'b0;
            w_col_vis    = 1'b1;
            w_pix_nxt    = PIX_ON_ENTRY;
          end
        end
      end
      ST_SCAN: begin
        // A stalled cycle keeps every register and visibility as it is.
        w_row_vis = 1'b1;
        w_col_vis = !r_settle;
        if (!adc_busy) begin
          if (r_settle) begin
            if (r_cnt == SETTLE_LAST) begin
              w_settle_nxt = 1'b0;
              w_cnt_nxt    = '0;
              w_col_vis    = 1'b1;
              w_pix_nxt    = PIX_ON_ENTRY;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else if (r_cnt != DWELL_LAST) begin
            w_cnt_nxt = w_cnt_inc;
            w_pix_nxt = (w_cnt_inc == DWELL_LAST);
          end else if (r_stare) begin
            w_cnt_nxt = '0;
            w_pix_nxt = PIX_ON_ENTRY;
          end else if (!w_col_last) begin
            w_col_en  = 1'b1;
            w_cnt_nxt = '0;
            w_pix_nxt = PIX_ON_ENTRY;
          end else if (!w_row_last) begin
            w_row_en   = 1'b1;
            w_col_load = 1'b1;
            w_cnt_nxt  = '0;
            if (ROW_SETTLE > 0) begin
              w_settle_nxt = 1'b1;
              w_col_vis    = 1'b0;
            end else begin
              w_pix_nxt = PIX_ON_ENTRY;
            end
          end else begin
            w_state_nxt = ST_DONE;
            w_row_vis   = 1'b0;
            w_col_vis   = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    // fsync restarts the handshake from any state and beats a final pixel.
    if (fsync) begin
      w_state_nxt = ST_WAIT_INTG;
      w_row_load  = 1'b0;
      w_row_en    = 1'b0;
      w_col_load  = 1'b0;
      w_col_en    = 1'b0;
      w_row_vis   = 1'b0;
      w_col_vis   = 1'b0;
      w_pix_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (master_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_settle <= 1'b0;
      r_pix    <= 1'b0;
      r_done   <= 1'b0;
      r_r0     <= '0;
      r_r1     <= '0;
      r_c0     <= '0;
      r_c1     <= '0;
      r_dec2   <= 1'b0;
      r_stare  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_settle <= w_settle_nxt;
      r_pix    <= w_pix_nxt;
      r_done   <= w_done_nxt;
      if (fsync) begin
        r_r0 <= RW'(clamp_window(32'(win_r0), 32'(win_r1), ROWS, 1'b0));
        r_r1 <= RW'(clamp_window(32'(win_r0), 32'(win_r1), ROWS, 1'b1));
        r_c0 <= CW'(clamp_window(32'(win_c0), 32'(win_c1), COLS, 1'b0));
        r_c1 <= CW'(clamp_window(32'(win_c0), 32'(win_c1), COLS, 1'b1));
        case (mode)
          MODE_DEC2:  begin r_dec2 <= 1'b1; r_stare <= 1'b0; end
          MODE_STARE: begin r_dec2 <= 1'b0; r_stare <= 1'b1; end
          MODE_FULL:  begin r_dec2 <= 1'b0; r_stare <= 1'b0; end
          default:    begin r_dec2 <= 1'b0; r_stare <= 1'b0; end
        endcase
      end
    end
  end

  scan_axis_counter #(.N(ROWS), .W(RW)) u_row_axis (
    .clk      (clk),
    .i_rst    (master_rst),
    .i_load   (w_row_load),
    .i_en     (w_row_en),
    .i_step2  (r_dec2),
    .i_start  (r_r0),
    .i_stop   (r_r1),
    .i_vis    (w_row_vis),
    .o_idx    (row_idx),
    .o_onehot (row),
    .o_last   (w_row_last)
  );

  scan_axis_counter #(.N(COLS), .W(CW)) u_col_axis (
    .clk      (clk),
    .i_rst    (master_rst),
    .i_load   (w_col_load),
    .i_en     (w_col_en),
    .i_step2  (r_dec2),
    .i_start  (r_c0),
    .i_stop   (r_c1),
    .i_vis    (w_col_vis),
    .o_idx    (col_idx),
    .o_onehot (col),
    .o_last   (w_col_last)
  );

  assign pix_valid  = r_pix;
  assign frame_done = r_done;
  assign state      = r_state;

endmodule

// File: tb/tb_roic_pixel_scanner.sv
// Self-checking bench for roic_pixel_scanner: table-driven frames, a stall,
// stare/abort/reset sequences and random frames against a pixel-list model.
module tb_roic_pixel_scanner;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int DWELL = 3;
  localparam int ROW_SETTLE = 1;

  logic        clk = 1'b0;
  logic        master_rst, fsync, intg, adc_busy;
  logic [1:0]  mode;
  logic [3:0]  win_r0, win_r1, win_c0, win_c1;
  logic [15:0] row, col;
  logic        pix_valid, frame_done;
  logic [3:0]  row_idx, col_idx;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_err = 0;
  int obs_q[$];
  int exp_q[$];

  roic_pixel_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .ROW_SETTLE(ROW_SETTLE)
  ) dut (
    .clk(clk), .master_rst(master_rst), .fsync(fsync), .intg(intg), .mode(mode),
    .win_r0(win_r0), .win_r1(win_r1), .win_c0(win_c0), .win_c1(win_c1),
    .adc_busy(adc_busy), .row(row), .col(col), .pix_valid(pix_valid),
    .row_idx(row_idx), .col_idx(col_idx), .frame_done(frame_done), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pixel list of one frame, straight from the window/mode rules.
  function automatic void axis(input int s, input int e, input int n, output int lo, output int hi);
    hi = (e >= n) ? n - 1 : e;
    lo = s;
    if (lo > hi) begin lo = 0; hi = n - 1; end
  endfunction

  task automatic model_frame(input int m, input int r0, input int r1, input int c0, input int c1,
                             output int exp_scan);
    int rlo, rhi, clo, chi, step, nr, nc;
    axis(r0, r1, ROWS, rlo, rhi);
    axis(c0, c1, COLS, clo, chi);
    step = (m == 1) ? 2 : 1;
    exp_q.delete();
    nr = 0; nc = 0;
    for (int r = rlo; r <= rhi; r += step) begin
      nr++; nc = 0;
      for (int c = clo; c <= chi; c += step) begin
        exp_q.push_back(r * 256 + c);
        nc++;
      end
    end
    exp_scan = nr * (ROW_SETTLE + nc * DWELL);
  endtask

  task automatic compare_pixels();
    check("pix_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check("pix_order", obs_q[i], exp_q[i]);
  endtask

  task automatic wait_state(input int s, input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (int'(state) == s) seen = 1;
    end
    if (!seen) check("wait_state_timeout", int'(state), s);
  endtask

  task automatic run_frame(input int m, input int r0, input int r1, input int c0, input int c1,
                           input int stall_at, input int stall_len,
                           output int scan_cnt, output int done_cnt);
    int busy_left, prev_state;
    logic [15:0] prow, pcol;
    logic [3:0]  pri, pci;
    bit fin;
    obs_q.delete();
    scan_cnt = 0; done_cnt = 0; busy_left = stall_len; fin = 0;
    @(posedge clk); #1;
    fsync = 1; mode = 2'(m);
    win_r0 = 4'(r0); win_r1 = 4'(r1); win_c0 = 4'(c0); win_c1 = 4'(c1);
    @(posedge clk); #1;
    fsync = 0; mode = 2'($urandom);
    win_r0 = 4'($urandom); win_r1 = 4'($urandom); win_c0 = 4'($urandom); win_c1 = 4'($urandom);
    @(posedge clk); #1;
    intg = 1;
    repeat (9) @(posedge clk);
    #1; intg = 0;
    prev_state = 2; prow = row; pcol = col; pri = row_idx; pci = col_idx;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      if (adc_busy && prev_state == 3) begin
        check("stall_row", int'(row), int'(prow));
        check("stall_col", int'(col), int'(pcol));
        check("stall_idx", int'({row_idx, col_idx}), int'({pri, pci}));
        check("stall_pix", int'(pix_valid), 0);
      end
      if (state == 3'd3) begin
        scan_cnt++;
        check("row_onehot", int'(row), 1 << row_idx);
        if (col != '0) check("col_onehot", int'(col), 1 << col_idx);
        if (pix_valid) begin
          check("pix_col", int'(col), 1 << col_idx);
          obs_q.push_back(int'(row_idx) * 256 + int'(col_idx));
        end
      end else begin
        check("rowcol_off", int'({row, col}), 0);
      end
      if (frame_done) begin
        done_cnt++;
        check("done_after_scan", prev_state * 8 + int'(state), 3 * 8 + 4);
      end
      if (state == 3'd0) fin = 1;
      prow = row; pcol = col; pri = row_idx; pci = col_idx; prev_state = int'(state);
      if (adc_busy) begin
        busy_left--;
        if (busy_left == 0) adc_busy = 0;
      end else if (state == 3'd3 && scan_cnt - 1 == stall_at && busy_left > 0) begin
        adc_busy = 1;
      end
    end
    if (!fin) check("frame_timeout", int'(state), 0);
  endtask

  typedef struct {
    int m, r0, r1, c0, c1;
    int npix, fr, fc, lr, lc, scan;
  } vec_t;

  vec_t vec[6];

  initial begin
    int sc, dc, es, cnt;
    vec[0] = '{0, 0, 15, 0, 15, 256, 0, 0, 15, 15, 784};
    vec[1] = '{0, 2, 5, 4, 7, 16, 2, 4, 5, 7, 52};
    vec[2] = '{1, 0, 15, 0, 15, 64, 0, 0, 14, 14, 200};
    vec[3] = '{0, 0, 1, 12, 3, 32, 0, 0, 1, 15, 98};
    vec[4] = '{3, 3, 3, 5, 9, 5, 3, 5, 3, 9, 16};
    vec[5] = '{1, 1, 6, 3, 8, 9, 1, 3, 5, 7, 30};

    master_rst = 1; fsync = 0; intg = 0; adc_busy = 0; mode = 0;
    win_r0 = 0; win_r1 = 0; win_c0 = 0; win_c1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_rowcol", int'({row, col}), 0);
    check("rst_idx", int'({row_idx, col_idx}), 0);
    check("rst_strobes", int'({pix_valid, frame_done}), 0);
    master_rst = 0;

    foreach (vec[i]) begin
      run_frame(vec[i].m, vec[i].r0, vec[i].r1, vec[i].c0, vec[i].c1, -1, 0, sc, dc);
      check("tbl_npix", obs_q.size(), vec[i].npix);
      if (obs_q.size() > 0) begin
        check("tbl_first", obs_q[0], vec[i].fr * 256 + vec[i].fc);
        check("tbl_last", obs_q[obs_q.size() - 1], vec[i].lr * 256 + vec[i].lc);
      end
      check("tbl_scan_len", sc, vec[i].scan);
      check("tbl_done", dc, 1);
      model_frame(vec[i].m, vec[i].r0, vec[i].r1, vec[i].c0, vec[i].c1, es);
      compare_pixels();
    end

    // Stall of 5 cycles in the middle of column 1 of row 4.
    run_frame(0, 0, 15, 0, 15, 201, 5, sc, dc);
    model_frame(0, 0, 15, 0, 15, es);
    compare_pixels();
    check("stall_scan_len", sc, es + 5);
    check("stall_done", dc, 1);

    // Stare at (7,9): settle, then a strobe every DWELL cycles until fsync.
    @(posedge clk); #1;
    fsync = 1; mode = 2; win_r0 = 7; win_r1 = 10; win_c0 = 9; win_c1 = 12;
    @(posedge clk); #1;
    fsync = 0; mode = 0; intg = 1;
    repeat (3) @(posedge clk);
    #1; intg = 0;
    wait_state(3, 20);
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      check("stare_state", int'(state), 3);
      check("stare_pix", int'(pix_valid), int'(i > 0 && i % 3 == 0));
      if (i == 0) check("stare_settle_col", int'(col), 0);
      if (pix_valid) check("stare_pos", int'(row_idx) * 256 + int'(col_idx), 7 * 256 + 9);
    end
    fsync = 1; mode = 0; win_r0 = 0; win_r1 = 15; win_c0 = 0; win_c1 = 15;
    @(negedge clk);
    fsync = 0;
    check("stare_abort_state", int'(state), 1);
    check("stare_abort_rowcol", int'({row, col}), 0);

    // Abort at scan cycle 100 of a full frame.
    intg = 1;
    repeat (3) @(negedge clk);
    intg = 0;
    wait_state(3, 20);
    repeat (100) @(negedge clk);
    check("abort_pre_row", int'(row_idx), 2);
    fsync = 1;
    @(negedge clk);
    fsync = 0;
    check("abort_state", int'(state), 1);
    check("abort_col", int'(col), 0);
    check("abort_row", int'(row), 0);
    cnt = int'(frame_done);
    repeat (20) begin
      @(negedge clk);
      if (frame_done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    check("abort_hold_wait", int'(state), 1);

    // Reset in the middle of row 1.
    intg = 1;
    repeat (3) @(negedge clk);
    intg = 0;
    wait_state(3, 20);
    repeat (50) @(negedge clk);
    check("rst_pre_row", int'(row_idx), 1);
    master_rst = 1;
    @(negedge clk);
    check("midrst_state", int'(state), 0);
    check("midrst_rowcol", int'({row, col}), 0);
    check("midrst_idx", int'({row_idx, col_idx}), 0);
    check("midrst_strobes", int'({pix_valid, frame_done}), 0);
    master_rst = 0;
    @(negedge clk);
    check("post_rst_idle", int'(state), 0);

    // Random frames, optionally with a stall, against the model.
    for (int k = 0; k < 8; k++) begin
      int m, r0, r1, c0, c1, sat, slen;
      m  = $urandom_range(0, 2);
      if (m == 2) m = 3;
      r0 = $urandom_range(0, 15); r1 = $urandom_range(0, 15);
      c0 = $urandom_range(0, 15); c1 = $urandom_range(0, 15);
      model_frame(m, r0, r1, c0, c1, es);
      sat = -1; slen = 0;
      if ($urandom_range(0, 1) == 1 && es > 2) begin
        sat  = $urandom_range(0, es - 2);
        slen = $urandom_range(1, 4);
      end
      run_frame(m, r0, r1, c0, c1, sat, slen, sc, dc);
      compare_pixels();
      check("rnd_scan_len", sc, es + slen);
      check("rnd_done", dc, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
